formula_pipe_flow_ctrl: RTL

Adds valid/ready flow control around a fixed-latency, no-stall formula pipe such as the three-isqrt formula_1 pipe, which cannot be stalled once arguments enter. The block sits upstream and downstream of that pipe. It admits argument triples only when space for their results is already reserved in an output FIFO. It buffers results until the downstream consumer accepts them, so backpressure never drops data.

---
 rtl/formula_pipe_flow_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/formula_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : formula_pipe_flow_ctrl
// Description : Valid/ready wrapper around a fixed-latency, non-stallable
//               formula pipe. Triples are admitted only while a credit is
//               free, so every result the pipe emits already has a reserved
//               slot in the output FIFO. Results are held in that FIFO until
//               the downstream consumer takes them.
// Ports       : clk, rst (async, active-low)
//               up_vld/up_rdy/a/b/c            - upstream argument triples
//               pipe_arg_vld/pipe_a/b/c        - to the formula pipe
//               pipe_res_vld/pipe_res          - from the formula pipe
//               down_vld/down_rdy/down_data    - downstream results
//               credits                        - free credits (debug)
//               err_ovf                        - sticky FIFO overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module formula_pipe_flow_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_vld,
  output logic                     up_rdy,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [WIDTH-1:0]         c,
  output logic                     pipe_arg_vld,
  output logic [WIDTH-1:0]         pipe_a,
  output logic [WIDTH-1:0]         pipe_b,
  output logic [WIDTH-1:0]         pipe_c,
  input  logic                     pipe_res_vld,
  input  logic [WIDTH-1:0]         pipe_res,
  output logic                     down_vld,
  input  logic                     down_rdy,
  output logic [WIDTH-1:0]         down_data,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [CW-1:0]    r_credits;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err_ovf;

  logic w_up_fire;
  logic w_down_fire;
  logic w_full;
  logic w_wr_en;
  logic w_ovf;

  // up_rdy depends on registered credits only, so no combinational path
  // exists from any valid/ready input back to it.
  assign up_rdy      = (r_credits != '0);
  assign w_up_fire   = up_vld & up_rdy;
  assign down_vld    = (r_count != '0);
  assign w_down_fire = down_vld & down_rdy;
  assign w_full      = (r_count == FULL_CNT);

  // A full FIFO can still take a write when the head leaves on the same edge.
  assign w_wr_en = pipe_res_vld & (~w_full | w_down_fire);
  assign w_ovf   = pipe_res_vld & w_full & ~w_down_fire;

  // Arguments are zeroed when not firing to keep the pipe datapath quiet.
  assign pipe_arg_vld = w_up_fire;
  assign pipe_a       = w_up_fire ? a : '0;
  assign pipe_b       = w_up_fire ? b : '0;
  assign pipe_c       = w_up_fire ? c : '0;

  assign down_data = r_mem[r_rd_ptr];
  assign credits   = r_credits;
  assign err_ovf   = r_err_ovf;

  // A credit is taken on acceptance and returned only when the result
  // leaves the FIFO, covering both in-flight and buffered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits <= FULL_CNT;
    end else if (w_up_fire && !w_down_fire) begin
      r_credits <= r_credits - ONE_CNT;
    end else if (!w_up_fire && w_down_fire) begin
      r_credits <= r_credits + ONE_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_down_fire) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
      if (w_wr_en && !w_down_fire) begin
        r_count <= r_count + ONE_CNT;
      end else if (!w_wr_en && w_down_fire) begin
        r_count <= r_count - ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_err_ovf <= 1'b1;
    end
  end

  // Storage array carries no reset; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= pipe_res;
    end
  end

endmodule
`default_nettype wire
